if_id_skid_buffer: RTL
======================

Name: if_id_skid_buffer

Overview:
- IF/ID pipeline boundary between instruction fetch and decode.
- Captures each {instruction, pc} beat from fetch and presents it to decode through a valid/ready handshake.
- Two-entry skid buffer: decode backpressure never drops an in-flight fetch beat.
- Flush clears the buffer on a taken branch or redirect.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- INSTR_WIDTH, 32, instruction width in bits.
- NOP_INSTR, 32'h00000013, value driven on out_instr when no valid entry is held (addi x0,x0,0).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a beat.
- in_ready  output  1  buffer can accept a beat this cycle.
- in_instr  input  INSTR_WIDTH  fetched instruction.
- in_pc  input  ADDR_WIDTH  PC of the fetched instruction.
- flush  input  1  discard all held and incoming beats.
- out_valid  output  1  decode-side beat valid.
- out_ready  input  1  decode accepts the beat.
- out_instr  output  INSTR_WIDTH  instruction to decode.
- out_pc  output  ADDR_WIDTH  PC to decode.
- out_misaligned  output  1  out_pc[1:0] != 0, qualified by out_valid.

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high (reset).
  - Reset clears main_valid and skid_valid.
  - Outputs after reset: out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0, out_misaligned=0.
- Storage:
  - main entry {instr, pc, valid} drives the outputs.
  - skid entry {instr, pc, valid} holds one overflow beat.
- Handshakes:
  - in_ready = !skid_valid (registered state only, no combinational path from out_ready).
  - Input accept = in_valid && in_ready && !flush.
  - Output transfer = out_valid && out_ready.
- Latency: one cycle from input accept to out_valid when the buffer is empty.
- State transitions, per edge, {main_valid, skid_valid} (EMPTY=00, ONE=10, FULL=11):
  - EMPTY: accept -> load main -> ONE; otherwise stay.
  - ONE, transfer and accept: main <= input, stay ONE.
  - ONE, transfer only: -> EMPTY.
  - ONE, accept only: skid <= input -> FULL.
  - ONE, neither: hold.
  - FULL, transfer: main <= skid, skid_valid <= 0 -> ONE (in_ready was 0, so no accept is possible).
  - FULL, no transfer: hold; in_ready=0.
- Ordering: beats leave strictly in acceptance order; no duplication, no loss.
- Flush:
  - Flush at an edge forces EMPTY and drops the incoming beat, overriding all other transitions.
  - Any out_ready transfer asserted in the same cycle is still considered taken by decode; the buffer ignores it beyond clearing.
- Output data:
  - out_instr = main instr when main_valid, else NOP_INSTR.
  - out_pc = main pc when main_valid, else 0.
- Reset priority: reset has priority over flush and all handshakes; mid-operation reset drops all entries at the next edge.
- Stability: while out_valid && !out_ready, out_instr and out_pc hold stable.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles [31:0].
  - Increments each cycle with in_valid && !in_ready && !flush.
  - Saturates at 32'hFFFFFFFF; cleared by reset only.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32 and ILEN=32 constants.
  - NOP_INSTR constant 32'h00000013.
  - typedef fetch_beat_t {instr, pc}.
- Sub-module: none; the two entries are small enough to stay inline.

Test Plan:
- Reset then in_valid=1, in_instr=32'h00500093, in_pc=0x0, out_ready=1 -> next cycle out_valid=1, out_instr=32'h00500093, out_pc=0x0; in_ready stays 1.
- Stream pc 0x0,0x4,0x8,0xC every cycle with out_ready held 0 from cycle 1:
  - in_ready drops after the 2nd beat.
  - Release out_ready -> outputs pc 0x0,0x4 then 0x8,0xC in order, none lost.
- FULL state (pcs 0x10,0x14) with flush=1 and in_valid=1 (pc 0x18):
  - next cycle out_valid=0, in_ready=1, out_instr=32'h00000013.
  - pc 0x18 never appears.
- in_pc=0x22 accepted -> out_misaligned=1 with out_valid.
  - Then pc 0x24 -> out_misaligned=0.
- reset asserted for one cycle while FULL -> next cycle out_valid=0, in_ready=1, out_pc=0.
- With IF_ID_STALL_CNT_EN: in_valid held 1, out_ready 0 for 10 cycles from empty -> stall_cycles=8.
  - Flush cycles are not counted.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used across the IF/ID boundary.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_beat_t;

  // Encoding is {main_valid, skid_valid} so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/if_id_skid_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID skid buffer.
interface if_id_skid_buffer_if
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH  = XLEN,
  parameter int INSTR_WIDTH = ILEN
);

  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic [ADDR_WIDTH-1:0]  in_pc;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic                   out_misaligned;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_misaligned
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_misaligned
  );

endinterface

// File: rtl/if_id_skid_buffer.sv
// IF/ID two-entry skid buffer; optional stall counter behind IF_ID_STALL_CNT_EN.
// Latency: one cycle from accept to out_valid when empty.
// Backpressure: in_ready = !skid_valid (registered), so decode stalls never drop a fetch beat.
module if_id_skid_buffer
  import riscv_pkg::*;
#(
  parameter int                     ADDR_WIDTH  = XLEN,
  parameter int                     INSTR_WIDTH = ILEN,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(riscv_pkg::NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  reset,
  if_id_skid_buffer_if.slave    bus
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } beat_t;

  skid_state_e state_q, state_d;
  beat_t       main_q, skid_q, in_beat;
  logic        main_valid, skid_valid;
  logic        accept, xfer;
  logic        load_main_in, load_main_skid, load_skid;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_beat    = '{instr: bus.in_instr, pc: bus.in_pc};

  assign accept = bus.in_valid && !skid_valid && !bus.flush;
  assign xfer   = main_valid && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (xfer && accept) begin
          load_main_in = 1'b1;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          load_main_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over every transition; a same-cycle decode transfer is simply absorbed.
    if (bus.flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload needs no reset: outputs are masked by main_valid.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_q <= in_beat;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= in_beat;
    end
  end

  assign bus.in_ready       = !skid_valid;
  assign bus.out_valid      = main_valid;
  assign bus.out_instr      = main_valid ? main_q.instr : NOP_INSTR;
  assign bus.out_pc         = main_valid ? main_q.pc : '0;
  assign bus.out_misaligned = main_valid && (main_q.pc[1:0] != 2'b00);

`ifdef IF_ID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (bus.in_valid && skid_valid && !bus.flush && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
